// File: rtl/sc_run_controller.sv
// sc_run_controller: program-load / run / halt / single-step controller for a small CPU.
// Owns the CPU reset and advance enable, streams loader words into instruction memory,
// and stops the CPU on a PC breakpoint.
module sc_run_controller (
  input  logic        clock,
  input  logic        resetn,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic        run_req,
  input  logic        halt_req,
  input  logic        step_req,
  input  logic        abort_req,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  output logic        cpu_resetn,
  output logic        cpu_clk_en,
  output logic        imem_we,
  output logic [5:0]  imem_waddr,
  output logic [31:0] imem_wdata,
  output logic [1:0]  state,
  output logic [31:0] cycle_count,
  output logic        bp_hit
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 6;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_HALT = 2'b11;

  logic [ADDR_W-1:0] load_ptr;
  logic              skip;
  logic              step_flag;
  logic              bp_match;

  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] load_ptr_nxt;
  logic              skip_nxt;
  logic              step_flag_nxt;
  logic              load_ready_nxt;
  logic              cpu_resetn_nxt;
  logic              imem_we_nxt;
  logic [ADDR_W-1:0] imem_waddr_nxt;
  logic [DATA_W-1:0] imem_wdata_nxt;
  logic [DATA_W-1:0] cycle_count_nxt;
  logic              bp_hit_nxt;

  // Breakpoint comparison, masked for the first cycle after resuming from HALT
  always_comb begin
    bp_match = bp_en && (pc == bp_addr) && !skip;
  end

  // CPU advance enable: free-running in RUN unless a breakpoint hits, one step pulse in HALT
  always_comb begin
    cpu_clk_en = 1'b0;
    case (state)
      ST_RUN:  cpu_clk_en = !bp_match;
      ST_HALT: cpu_clk_en = step_flag;
      default: cpu_clk_en = 1'b0;
    endcase
  end

  // Next-state and next-register-value logic; abort always wins over other requests
  always_comb begin
    state_nxt      = state;
    load_ptr_nxt   = load_ptr;
    skip_nxt       = 1'b0;
    step_flag_nxt  = 1'b0;
    imem_we_nxt    = 1'b0;
    imem_waddr_nxt = imem_waddr;
    imem_wdata_nxt = imem_wdata;
    bp_hit_nxt     = bp_hit;
    cycle_count_nxt = (cpu_clk_en && (cycle_count != {DATA_W{1'b1}}))
                      ? cycle_count + DATA_W'(1) : cycle_count;

    case (state)
      ST_IDLE: begin
        if (load_start) begin
          state_nxt    = ST_LOAD;
          load_ptr_nxt = '0;
        end else if (run_req) begin
          state_nxt       = ST_RUN;
          cycle_count_nxt = '0;
          bp_hit_nxt      = 1'b0;
        end
      end
      ST_LOAD: begin
        if (abort_req) begin
          state_nxt = ST_IDLE;
        end else if (load_valid && load_ready) begin
          imem_we_nxt    = 1'b1;
          imem_waddr_nxt = load_ptr;
          imem_wdata_nxt = load_data;
          load_ptr_nxt   = load_ptr + ADDR_W'(1);
          if (load_last) state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_req) begin
          state_nxt = ST_IDLE;
        end else if (halt_req) begin
          state_nxt = ST_HALT;
        end else if (bp_match) begin
          state_nxt  = ST_HALT;
          bp_hit_nxt = 1'b1;
        end
      end
      ST_HALT: begin
        if (abort_req) begin
          state_nxt = ST_IDLE;
        end else if (run_req) begin
          state_nxt  = ST_RUN;
          skip_nxt   = 1'b1;
          bp_hit_nxt = 1'b0;
        end else if (step_req) begin
          step_flag_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    load_ready_nxt = (state_nxt == ST_LOAD);
    cpu_resetn_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_HALT);
  end

  // State and output registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      load_ptr    <= '0;
      skip        <= 1'b0;
      step_flag   <= 1'b0;
      load_ready  <= 1'b0;
      cpu_resetn  <= 1'b0;
      imem_we     <= 1'b0;
      imem_waddr  <= '0;
      imem_wdata  <= '0;
      cycle_count <= '0;
      bp_hit      <= 1'b0;
    end else begin
      state       <= state_nxt;
      load_ptr    <= load_ptr_nxt;
      skip        <= skip_nxt;
      step_flag   <= step_flag_nxt;
      load_ready  <= load_ready_nxt;
      cpu_resetn  <= cpu_resetn_nxt;
      imem_we     <= imem_we_nxt;
      imem_waddr  <= imem_waddr_nxt;
      imem_wdata  <= imem_wdata_nxt;
      cycle_count <= cycle_count_nxt;
      bp_hit      <= bp_hit_nxt;
    end
  end

endmodule
